// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multicycle MIPS control unit: opcodes, FSM states,
// opcode classes and the datapath mux/ALU select encodings.
package mc_ctrl_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC_R,
    S_RWB,
    S_EXEC_I,
    S_IWB,
    S_BRANCH,
    S_JUMP,
    S_ERROR
  } state_e;

  // Dispatch groups used by DECODE; loads and stores share the address step.
  typedef enum logic [2:0] {
    CL_MEM,
    CL_RTYPE,
    CL_ADDI,
    CL_BRANCH,
    CL_JUMP,
    CL_ILLEGAL
  } op_class_e;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  function automatic op_class_e classify(input logic [5:0] op);
    op_class_e c;
    case (op)
      OP_LW, OP_SW:   c = CL_MEM;
      OP_RTYPE:       c = CL_RTYPE;
      OP_ADDI:        c = CL_ADDI;
      OP_BEQ, OP_BNE: c = CL_BRANCH;
      OP_J:           c = CL_JUMP;
      default:        c = CL_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational strobe decode for the multicycle control unit. Outputs are a
// pure function of the registered state, plus mem_ready (FETCH/MEMWR) and
// opcode (DECODE legality, BRANCH sense).
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  state_e              state,
  input  logic                mem_ready,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                mem_req,
  output logic                mem_read,
  output logic                mem_write,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                branch_ne,
  output logic [1:0]          pc_source,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          aluop,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                instr_done,
  output logic                illegal,
  output logic                err
);

  logic [5:0] op6;
  assign op6 = 6'(opcode);

  // Per-state strobe table; everything defaults to 0 (IDLE and ERROR rely on it).
  always_comb begin
    mem_req       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = PCSRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    aluop         = ALUOP_ADD;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    err           = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        // IR and PC+4 are only committed on the cycle the word arrives.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        illegal   = (classify(op6) == CL_ILLEGAL);
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_FUNCT;
      end
      S_RWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        aluop         = ALUOP_SUB;
        pc_source     = PCSRC_ALUOUT;
        pc_write_cond = 1'b1;
        branch_ne     = (op6 == OP_BNE);
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_source  = PCSRC_JUMP;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      S_ERROR: begin
        err = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register, next-state logic and memory
// wait-timeout counter; strobes come from mc_ctrl_outdec.
// Optional build macro PERF_CNT_EN adds retired_cnt / stall_cnt outputs.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | halted, waiting for en
// FETCH    | instruction read from PC, waits on mem_ready
// DECODE   | register read, branch target calc, dispatch
// MEMADR   | LW/SW effective address
// MEMRD    | data read, waits on mem_ready
// MEMWB    | load write-back (terminal)
// MEMWR    | data write, waits on mem_ready (terminal)
// EXEC_R   | R-type ALU operation
// RWB      | R-type write-back (terminal)
// EXEC_I   | ADDI ALU operation
// IWB      | ADDI write-back (terminal)
// BRANCH   | BEQ/BNE compare and conditional PC load (terminal)
// JUMP     | PC <- jump target (terminal)
// ERROR    | memory timeout, left only by rst
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int OPCODE_W     = 6,
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_read,
  output logic                mem_write,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                branch_ne,
  output logic [1:0]          pc_source,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          aluop,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                instr_done,
  output logic                illegal,
`ifdef PERF_CNT_EN
  output logic [31:0]         retired_cnt,
  output logic [31:0]         stall_cnt,
`endif
  output logic                err
);

  // WAIT_TIMEOUT must be at least 2 so the limit below is a real wait.
  localparam int CNT_W = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(WAIT_TIMEOUT - 1);

  state_e          state;
  state_e          after_instr;
  logic [CNT_W-1:0] wait_cnt;
  logic            in_mem_state;
  logic            wait_expired;
  op_class_e       op_class;

  assign in_mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign wait_expired = (wait_cnt == WAIT_LIMIT);
  assign after_instr  = en ? S_FETCH : S_IDLE;
  assign op_class     = classify(6'(opcode));

  // State register, dispatch and wait counter; mem_ready beats the timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      if (in_mem_state && !mem_ready && !wait_expired)
        wait_cnt <= wait_cnt + CNT_W'(1);
      else
        wait_cnt <= '0;

      case (state)
        S_IDLE:   if (en) state <= S_FETCH;
        S_FETCH: begin
          if (mem_ready)         state <= S_DECODE;
          else if (wait_expired) state <= S_ERROR;
        end
        S_DECODE: begin
          case (op_class)
            CL_MEM:    state <= S_MEMADR;
            CL_RTYPE:  state <= S_EXEC_R;
            CL_ADDI:   state <= S_EXEC_I;
            CL_BRANCH: state <= S_BRANCH;
            CL_JUMP:   state <= S_JUMP;
            default:   state <= after_instr;
          endcase
        end
        S_MEMADR: state <= (6'(opcode) == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD: begin
          if (mem_ready)         state <= S_MEMWB;
          else if (wait_expired) state <= S_ERROR;
        end
        S_MEMWR: begin
          if (mem_ready)         state <= after_instr;
          else if (wait_expired) state <= S_ERROR;
        end
        S_EXEC_R: state <= S_RWB;
        S_EXEC_I: state <= S_IWB;
        S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: state <= after_instr;
        S_ERROR:  state <= S_ERROR;
        default:  state <= S_IDLE;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  // Retired-instruction and memory-stall counters, free-running with wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (instr_done)                 retired_cnt <= retired_cnt + 32'd1;
      if (in_mem_state && !mem_ready) stall_cnt   <= stall_cnt + 32'd1;
    end
  end
`endif

  mc_ctrl_outdec #(
    .OPCODE_W (OPCODE_W)
  ) u_outdec (
    .state         (state),
    .mem_ready     (mem_ready),
    .opcode        (opcode),
    .mem_req       (mem_req),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .iord          (iord),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_ne     (branch_ne),
    .pc_source     (pc_source),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .aluop         (aluop),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .instr_done    (instr_done),
    .illegal       (illegal),
    .err           (err)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. All outputs are packed into one
// 21-bit vector and compared against hand-written per-state expectations.
module tb_multicycle_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  // {req,rd,wr,iord} {irw,pcw,pwc,bne} pcsrc srca srcb aluop {rdst,m2r,rw,done,ill,err}
  localparam logic [20:0] E_IDLE    = 21'd0;
  localparam logic [20:0] E_FETCH_W = {4'b1100, 4'b0000, 2'b00, 1'b0, 2'b01, 2'b00, 6'b000000};
  localparam logic [20:0] E_FETCH_R = {4'b1100, 4'b1100, 2'b00, 1'b0, 2'b01, 2'b00, 6'b000000};
  localparam logic [20:0] E_DECODE  = {4'b0000, 4'b0000, 2'b00, 1'b0, 2'b11, 2'b00, 6'b000000};
  localparam logic [20:0] E_DEC_ILL = {4'b0000, 4'b0000, 2'b00, 1'b0, 2'b11, 2'b00, 6'b000010};
  localparam logic [20:0] E_MEMADR  = {4'b0000, 4'b0000, 2'b00, 1'b1, 2'b10, 2'b00, 6'b000000};
  localparam logic [20:0] E_MEMRD   = {4'b1101, 4'b0000, 2'b00, 1'b0, 2'b00, 2'b00, 6'b000000};
  localparam logic [20:0] E_MEMWB   = {4'b0000, 4'b0000, 2'b00, 1'b0, 2'b00, 2'b00, 6'b011100};
  localparam logic [20:0] E_MEMWR_W = {4'b1011, 4'b0000, 2'b00, 1'b0, 2'b00, 2'b00, 6'b000000};
  localparam logic [20:0] E_MEMWR_R = {4'b1011, 4'b0000, 2'b00, 1'b0, 2'b00, 2'b00, 6'b000100};
  localparam logic [20:0] E_EXEC_R  = {4'b0000, 4'b0000, 2'b00, 1'b1, 2'b00, 2'b10, 6'b000000};
  localparam logic [20:0] E_RWB     = {4'b0000, 4'b0000, 2'b00, 1'b0, 2'b00, 2'b00, 6'b101100};
  localparam logic [20:0] E_EXEC_I  = {4'b0000, 4'b0000, 2'b00, 1'b1, 2'b10, 2'b00, 6'b000000};
  localparam logic [20:0] E_IWB     = {4'b0000, 4'b0000, 2'b00, 1'b0, 2'b00, 2'b00, 6'b001100};
  localparam logic [20:0] E_BEQ     = {4'b0000, 4'b0010, 2'b01, 1'b1, 2'b00, 2'b01, 6'b000100};
  localparam logic [20:0] E_BNE     = {4'b0000, 4'b0011, 2'b01, 1'b1, 2'b00, 2'b01, 6'b000100};
  localparam logic [20:0] E_JUMP    = {4'b0000, 4'b0100, 2'b10, 1'b0, 2'b00, 2'b00, 6'b000100};
  localparam logic [20:0] E_ERR     = 21'd1;

  typedef struct packed {
    logic        en;
    logic        rdy;
    logic [5:0]  op;
    logic [20:0] exp;
  } step_t;

  logic clk, rst, en, mem_ready;
  logic [5:0] opcode;
  logic mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, branch_ne;
  logic [1:0] pc_source, alu_src_b, aluop;
  logic alu_src_a, reg_dst, mem_to_reg, reg_write, instr_done, illegal, err;
`ifdef PERF_CNT_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif
  logic [20:0] obs;

  int total = 0;
  int bad = 0;

  multicycle_control #(.OPCODE_W(6), .WAIT_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .branch_ne(branch_ne), .pc_source(pc_source), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .aluop(aluop), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .instr_done(instr_done), .illegal(illegal),
`ifdef PERF_CNT_EN
    .retired_cnt(retired_cnt), .stall_cnt(stall_cnt),
`endif
    .err(err)
  );

  assign obs = {mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
                branch_ne, pc_source, alu_src_a, alu_src_b, aluop, reg_dst, mem_to_reg,
                reg_write, instr_done, illegal, err};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; mem_ready = 1'b1; opcode = OP_LW;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs !== E_IDLE) begin bad++; $display("FAIL reset_hold: got %h want %h", obs, E_IDLE); end
    en = 1'b0; rst = 1'b0; #1;
    total++;
    if (obs !== E_IDLE) begin bad++; $display("FAIL reset_release: got %h want %h", obs, E_IDLE); end
    @(posedge clk); #1;
    total++;
    if (obs !== E_IDLE) begin bad++; $display("FAIL idle_en0: got %h want %h", obs, E_IDLE); end
  endtask

  task automatic test_lw;
    step_t t [7];
    t = '{'{1'b1, 1'b1, OP_LW, E_IDLE}, '{1'b1, 1'b1, OP_LW, E_FETCH_R},
          '{1'b1, 1'b1, OP_LW, E_DECODE}, '{1'b1, 1'b1, OP_LW, E_MEMADR},
          '{1'b1, 1'b1, OP_LW, E_MEMRD}, '{1'b0, 1'b1, OP_LW, E_MEMWB},
          '{1'b0, 1'b0, OP_LW, E_IDLE}};
    foreach (t[i]) begin
      en = t[i].en; mem_ready = t[i].rdy; opcode = t[i].op; #1;
      total++;
      if (obs !== t[i].exp) begin bad++; $display("FAIL lw step %0d: got %h want %h", i, obs, t[i].exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch;
    step_t t [10];
    t = '{'{1'b1, 1'b1, OP_BNE, E_IDLE}, '{1'b1, 1'b1, OP_BNE, E_FETCH_R},
          '{1'b1, 1'b1, OP_BNE, E_DECODE}, '{1'b0, 1'b1, OP_BNE, E_BNE},
          '{1'b0, 1'b1, OP_BNE, E_IDLE},
          '{1'b1, 1'b1, OP_BEQ, E_IDLE}, '{1'b1, 1'b1, OP_BEQ, E_FETCH_R},
          '{1'b1, 1'b1, OP_BEQ, E_DECODE}, '{1'b0, 1'b1, OP_BEQ, E_BEQ},
          '{1'b0, 1'b1, OP_BEQ, E_IDLE}};
    foreach (t[i]) begin
      en = t[i].en; mem_ready = t[i].rdy; opcode = t[i].op; #1;
      total++;
      if (obs !== t[i].exp) begin bad++; $display("FAIL branch step %0d: got %h want %h", i, obs, t[i].exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_wait;
    step_t t [9];
    t = '{'{1'b1, 1'b1, OP_SW, E_IDLE}, '{1'b1, 1'b1, OP_SW, E_FETCH_R},
          '{1'b1, 1'b1, OP_SW, E_DECODE}, '{1'b1, 1'b0, OP_SW, E_MEMADR},
          '{1'b1, 1'b0, OP_SW, E_MEMWR_W}, '{1'b1, 1'b0, OP_SW, E_MEMWR_W},
          '{1'b1, 1'b0, OP_SW, E_MEMWR_W}, '{1'b0, 1'b1, OP_SW, E_MEMWR_R},
          '{1'b0, 1'b0, OP_SW, E_IDLE}};
    foreach (t[i]) begin
      en = t[i].en; mem_ready = t[i].rdy; opcode = t[i].op; #1;
      total++;
      if (obs !== t[i].exp) begin bad++; $display("FAIL sw_wait step %0d: got %h want %h", i, obs, t[i].exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal;
    step_t t [11];
    t = '{'{1'b1, 1'b1, OP_BAD, E_IDLE}, '{1'b1, 1'b1, OP_BAD, E_FETCH_R},
          '{1'b1, 1'b1, OP_BAD, E_DEC_ILL}, '{1'b1, 1'b1, OP_ADDI, E_FETCH_R},
          '{1'b1, 1'b1, OP_ADDI, E_DECODE}, '{1'b1, 1'b1, OP_ADDI, E_EXEC_I},
          '{1'b0, 1'b1, OP_ADDI, E_IWB},
          '{1'b1, 1'b1, OP_BAD, E_IDLE}, '{1'b1, 1'b1, OP_BAD, E_FETCH_R},
          '{1'b0, 1'b1, OP_BAD, E_DEC_ILL}, '{1'b0, 1'b1, OP_BAD, E_IDLE}};
    foreach (t[i]) begin
      en = t[i].en; mem_ready = t[i].rdy; opcode = t[i].op; #1;
      total++;
      if (obs !== t[i].exp) begin bad++; $display("FAIL illegal step %0d: got %h want %h", i, obs, t[i].exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_en_drop;
    step_t t [12];
    t = '{'{1'b1, 1'b1, OP_RTYPE, E_IDLE}, '{1'b1, 1'b1, OP_RTYPE, E_FETCH_R},
          '{1'b0, 1'b1, OP_RTYPE, E_DECODE}, '{1'b0, 1'b1, OP_RTYPE, E_EXEC_R},
          '{1'b0, 1'b1, OP_RTYPE, E_RWB}, '{1'b0, 1'b1, OP_RTYPE, E_IDLE},
          '{1'b1, 1'b1, OP_J, E_IDLE}, '{1'b1, 1'b0, OP_J, E_FETCH_W},
          '{1'b1, 1'b1, OP_J, E_FETCH_R}, '{1'b1, 1'b1, OP_J, E_DECODE},
          '{1'b0, 1'b1, OP_J, E_JUMP}, '{1'b0, 1'b1, OP_J, E_IDLE}};
    foreach (t[i]) begin
      en = t[i].en; mem_ready = t[i].rdy; opcode = t[i].op; #1;
      total++;
      if (obs !== t[i].exp) begin bad++; $display("FAIL en_drop step %0d: got %h want %h", i, obs, t[i].exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    step_t t [13];
    t = '{'{1'b1, 1'b1, OP_J, E_IDLE}, '{1'b1, 1'b1, OP_J, E_FETCH_R},
          '{1'b1, 1'b1, OP_J, E_DECODE}, '{1'b1, 1'b1, OP_J, E_JUMP},
          '{1'b1, 1'b1, OP_ADDI, E_FETCH_R}, '{1'b1, 1'b1, OP_ADDI, E_DECODE},
          '{1'b1, 1'b1, OP_ADDI, E_EXEC_I}, '{1'b1, 1'b1, OP_ADDI, E_IWB},
          '{1'b1, 1'b1, OP_RTYPE, E_FETCH_R}, '{1'b1, 1'b1, OP_RTYPE, E_DECODE},
          '{1'b1, 1'b1, OP_RTYPE, E_EXEC_R}, '{1'b0, 1'b1, OP_RTYPE, E_RWB},
          '{1'b0, 1'b1, OP_RTYPE, E_IDLE}};
    foreach (t[i]) begin
      en = t[i].en; mem_ready = t[i].rdy; opcode = t[i].op; #1;
      total++;
      if (obs !== t[i].exp) begin bad++; $display("FAIL back_to_back step %0d: got %h want %h", i, obs, t[i].exp); end
      @(posedge clk); #1;
    end
  endtask

  // Ten waits in FETCH then ten in MEMRD: the counter must restart per state.
  task automatic test_wait_clear;
    logic [20:0] exp;
    en = 1'b1; opcode = OP_LW;
    for (int i = 0; i < 28; i++) begin
      mem_ready = !((i >= 1 && i <= 10) || (i >= 14 && i <= 23));
      if (i == 0)       exp = E_IDLE;
      else if (i <= 10) exp = E_FETCH_W;
      else if (i == 11) exp = E_FETCH_R;
      else if (i == 12) exp = E_DECODE;
      else if (i == 13) exp = E_MEMADR;
      else if (i <= 24) exp = E_MEMRD;
      else if (i == 25) exp = E_MEMWB;
      else              exp = E_IDLE;
      if (i >= 25) en = 1'b0;
      #1;
      total++;
      if (obs !== exp) begin bad++; $display("FAIL wait_clear step %0d: got %h want %h", i, obs, exp); end
      @(posedge clk); #1;
    end
  endtask

  // mem_ready on the 16th waiting cycle completes the fetch without error.
  task automatic test_timeout_boundary;
    logic [20:0] exp;
    en = 1'b1; opcode = OP_J;
    for (int i = 0; i < 20; i++) begin
      mem_ready = (i == 0) || (i >= 16);
      if (i == 0)       exp = E_IDLE;
      else if (i <= 15) exp = E_FETCH_W;
      else if (i == 16) exp = E_FETCH_R;
      else if (i == 17) exp = E_DECODE;
      else if (i == 18) exp = E_JUMP;
      else              exp = E_IDLE;
      if (i >= 18) en = 1'b0;
      #1;
      total++;
      if (obs !== exp) begin bad++; $display("FAIL timeout_edge step %0d: got %h want %h", i, obs, exp); end
      @(posedge clk); #1;
    end
  endtask

  // Sixteen silent cycles in a memory state end in sticky ERROR until rst.
  task automatic test_timeout_error(input logic [5:0] op, input int lead);
    logic [20:0] exp;
    en = 1'b1; opcode = op;
    for (int i = 0; i < lead + 16 + 4; i++) begin
      mem_ready = (i < lead) || (i >= lead + 16);
      if (i >= lead + 16)   exp = E_ERR;
      else if (i >= lead)   exp = (op == OP_LW) ? E_MEMRD : E_FETCH_W;
      else if (i == 0)      exp = E_IDLE;
      else if (i == 1)      exp = E_FETCH_R;
      else if (i == 2)      exp = E_DECODE;
      else                  exp = E_MEMADR;
      #1;
      total++;
      if (obs !== exp) begin bad++; $display("FAIL timeout op=%b step %0d: got %h want %h", op, i, obs, exp); end
      @(posedge clk); #1;
    end
    rst = 1'b1; en = 1'b0; #1;
    total++;
    if (obs !== E_IDLE) begin bad++; $display("FAIL timeout_rst: got %h want %h", obs, E_IDLE); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (obs !== E_IDLE) begin bad++; $display("FAIL timeout_after_rst: got %h want %h", obs, E_IDLE); end
  endtask

  // Async reset in the middle of a store wait, then a clean fetch wait.
  task automatic test_rst_mid_wait;
    step_t t [6];
    t = '{'{1'b1, 1'b1, OP_SW, E_IDLE}, '{1'b1, 1'b1, OP_SW, E_FETCH_R},
          '{1'b1, 1'b1, OP_SW, E_DECODE}, '{1'b1, 1'b0, OP_SW, E_MEMADR},
          '{1'b1, 1'b0, OP_SW, E_MEMWR_W}, '{1'b1, 1'b0, OP_SW, E_MEMWR_W}};
    foreach (t[i]) begin
      en = t[i].en; mem_ready = t[i].rdy; opcode = t[i].op; #1;
      total++;
      if (obs !== t[i].exp) begin bad++; $display("FAIL rst_wait step %0d: got %h want %h", i, obs, t[i].exp); end
      @(posedge clk); #1;
    end
    #2 rst = 1'b1; #1;
    total++;
    if (obs !== E_IDLE) begin bad++; $display("FAIL rst_wait async: got %h want %h", obs, E_IDLE); end
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b0; #1;
    total++;
    if (obs !== E_IDLE) begin bad++; $display("FAIL rst_wait release: got %h want %h", obs, E_IDLE); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mem_ready = 1'b0; opcode = '0;
    test_reset();
    test_lw();
    test_branch();
    test_sw_wait();
    test_illegal();
    test_en_drop();
    test_back_to_back();
    test_wait_clear();
    test_timeout_boundary();
    test_timeout_error(OP_J, 1);
    test_timeout_error(OP_LW, 4);
    test_rst_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
